switch_input_decoder: RTL and testbench

//   Input end of the switch-to-frog interface. Turns the four raw Go Board switches into debounced levels,
//   one-cycle move pulses and a game-reset request. Sits between the board pins and the frog mover and
//   the top-level reset logic. Moves are issued for single-switch presses only; the four-switch chord is

---
 rtl/frogger_pkg.sv | 22 ++
 rtl/switch_debounce.sv | 45 ++++
 rtl/switch_input_decoder.sv | 153 +++++++++++++++
 tb/tb_switch_input_decoder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// Shared definitions for the frogger switch interface: direction bit indices,
// chord FSM encodings and the system clock rate used to derive default timings.
package frogger_pkg;

  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  localparam int CLK_HZ = 25000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FIRED = 2'd2
  } chord_state_t;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// One switch: 2-FF synchroniser followed by a debounce counter that accepts a
// new level only after it has been seen continuously for DEBOUNCE_CYCLES cycles.
module switch_debounce
  import frogger_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = CLK_HZ / 100
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      // Any sample matching the accepted level restarts the qualification window
      if (r_sync == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_stable;

endmodule

// File: rtl/switch_input_decoder.sv
// Debounced switch levels, single-press move pulses and the four-switch game-reset chord.
// Optional AUTOREPEAT_EN adds repeat pulses while one switch stays held.
module switch_input_decoder
  import frogger_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = CLK_HZ / 100,
  parameter int COMBO_HOLD_CYCLES = CLK_HZ / 2,
  parameter int REPEAT_DELAY      = (CLK_HZ / 10) * 3,
  parameter int REPEAT_PERIOD     = (CLK_HZ / 20) * 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       switch1,
  input  logic       switch2,
  input  logic       switch3,
  input  logic       switch4,
  output logic       move_up,
  output logic       move_down,
  output logic       move_left,
  output logic       move_right,
  output logic       game_reset_req,
  output logic [3:0] sw_state
);

  localparam int HW = (COMBO_HOLD_CYCLES > 1) ? $clog2(COMBO_HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(COMBO_HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_PRE  = HW'(COMBO_HOLD_CYCLES - 2);
  localparam bit            HOLD_ONE  = (COMBO_HOLD_CYCLES == 1);

  logic [3:0]    w_raw;
  logic [3:0]    w_level;
  logic [3:0]    w_rise;
  logic          w_single;
  logic          w_idle;
  logic          w_all;
  logic          w_none;
  logic          w_fire_next;
  logic          w_rep_pulse;
  logic [3:0]    w_move_next;

  logic [3:0]    r_level_d;
  logic [3:0]    r_move;
  logic          r_req;
  chord_state_t  r_state;
  logic [HW-1:0] r_hold_cnt;

  assign w_raw = {switch4, switch3, switch2, switch1};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sw
    switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .i_raw  (w_raw[gi]),
      .o_level(w_level[gi])
    );
  end

  assign w_rise   = w_level & ~r_level_d;
  assign w_single = is_onehot4(w_level);
  assign w_idle   = (r_state == ST_IDLE);
  assign w_all    = (w_level == 4'hF);
  assign w_none   = (w_level == 4'h0);

  // The request is registered one cycle early so it coincides with the terminal hold count
  assign w_fire_next = HOLD_ONE ? (w_idle && w_all)
                                : ((r_state == ST_HOLD) && w_all && (r_hold_cnt == HOLD_PRE));

`ifdef AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] r_rep_cnt;
  logic          r_rep_first;
  logic          w_rep_hit;
  logic          w_rep_run;

  assign w_rep_run   = w_single && w_idle && (w_rise == 4'h0);
  assign w_rep_hit   = r_rep_first ? (r_rep_cnt == DELAY_LAST) : (r_rep_cnt == PERIOD_LAST);
  assign w_rep_pulse = w_rep_run && w_rep_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
    end else if (!w_rep_run) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
    end else if (w_rep_hit) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b0;
    end else begin
      r_rep_cnt <= r_rep_cnt + RW'(1);
    end
  end
`else
  assign w_rep_pulse = 1'b0;
`endif

  always_comb begin
    w_move_next = 4'h0;
    if (w_idle && w_single && ((w_rise != 4'h0) || w_rep_pulse)) begin
      w_move_next = w_level;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= '0;
      r_req      <= 1'b0;
      r_level_d  <= 4'h0;
      r_move     <= 4'h0;
    end else begin
      r_level_d <= w_level;
      r_move    <= w_move_next;
      r_req     <= w_fire_next;
      case (r_state)
        ST_IDLE: begin
          if (w_all) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= '0;
          end
        end
        ST_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_state <= ST_FIRED;
          end else if (!w_all) begin
            r_state <= ST_IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end
        ST_FIRED: begin
          // Re-arm only after a full release so one chord yields one request
          if (w_none) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign move_up        = r_move[DIR_UP];
  assign move_down      = r_move[DIR_DOWN];
  assign move_left      = r_move[DIR_LEFT];
  assign move_right     = r_move[DIR_RIGHT];
  assign game_reset_req = r_req;
  assign sw_state       = w_level;

endmodule

// File: tb/tb_switch_input_decoder.sv
// Bench for switch_input_decoder: directed scenarios with literal expectations plus
// randomized switch activity checked every cycle against a behavioural model.
module tb_switch_input_decoder;

  localparam int D  = 4;
  localparam int C  = 16;
  localparam int RD = 20;
  localparam int RP = 8;
`ifdef AUTOREPEAT_EN
  localparam int EXP_HOLD_PULSES = 6;
  localparam int EXP_AT_27       = 1;
`else
  localparam int EXP_HOLD_PULSES = 1;
  localparam int EXP_AT_27       = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       switch1 = 1'b0, switch2 = 1'b0, switch3 = 1'b0, switch4 = 1'b0;
  logic       move_up, move_down, move_left, move_right, game_reset_req;
  logic [3:0] sw_state;

  int total = 0;
  int bad   = 0;
  int n_mv[4];
  int n_req = 0;

  always #5 clk = ~clk;

  switch_input_decoder #(
    .DEBOUNCE_CYCLES  (D),
    .COMBO_HOLD_CYCLES(C),
    .REPEAT_DELAY     (RD),
    .REPEAT_PERIOD    (RP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .switch1       (switch1),
    .switch2       (switch2),
    .switch3       (switch3),
    .switch4       (switch4),
    .move_up       (move_up),
    .move_down     (move_down),
    .move_left     (move_left),
    .move_right    (move_right),
    .game_reset_req(game_reset_req),
    .sw_state      (sw_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] v);
    {switch4, switch3, switch2, switch1} = v;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0]  m_sw = 4'h0, m_sw_d = 4'h0, m_move = 4'h0;
  logic        m_req = 1'b0, m_fired = 1'b0;
  int          m_run = 0, m_k = 0;
  logic [15:0] m_rawh[4];

  initial begin
    logic [3:0]  raw, rise, new_sw, new_move;
    logic [15:0] mask, win;
    logic        nonidle, single, rep, new_req, new_fired;
    mask = (16'd1 << D) - 16'd1;
    for (int i = 0; i < 4; i++) m_rawh[i] = '0;
    forever begin
      @(posedge clk);
      raw = {switch4, switch3, switch2, switch1};
      if (reset) begin
        m_sw = 0; m_sw_d = 0; m_move = 0; m_req = 0; m_fired = 0; m_run = 0; m_k = 0;
        for (int i = 0; i < 4; i++) m_rawh[i] = '0;
      end else begin
        nonidle = m_fired || (m_sw_d == 4'hF);
        rise    = m_sw & ~m_sw_d;
        single  = ($countones(m_sw) == 1);
        rep     = 1'b0;
`ifdef AUTOREPEAT_EN
        if (!nonidle && single && rise == 4'h0) begin
          m_k++;
          rep = (m_k >= RD) && (((m_k - RD) % RP) == 0);
        end else begin
          m_k = 0;
        end
`endif
        new_move  = (!nonidle && single && (rise != 4'h0 || rep)) ? m_sw : 4'h0;
        new_req   = !m_fired && (m_run == C);
        new_fired = m_req || (m_fired && m_sw != 4'h0);
        for (int i = 0; i < 4; i++) begin
          win = (m_rawh[i] >> 1) & mask;
          new_sw[i] = m_sw[i];
          if (m_sw[i] ? (win == 16'd0) : (win == mask)) new_sw[i] = ~m_sw[i];
          m_rawh[i] = {m_rawh[i][14:0], raw[i]};
        end
        m_run   = (new_sw == 4'hF) ? m_run + 1 : 0;
        m_sw_d  = m_sw;
        m_sw    = new_sw;
        m_move  = new_move;
        m_req   = new_req;
        m_fired = new_fired;
      end
    end
  end

  // ---------------- per-cycle compare + event counters ----------------
  initial begin
    logic [8:0] act, exp;
    for (int i = 0; i < 4; i++) n_mv[i] = 0;
    forever begin
      @(negedge clk);
      act = {sw_state, move_right, move_left, move_down, move_up, game_reset_req};
      exp = reset ? 9'd0 : {m_sw, m_move, m_req};
      check("cycle_model", {23'd0, act}, {23'd0, exp});
      if (move_up)    n_mv[0]++;
      if (move_down)  n_mv[1]++;
      if (move_left)  n_mv[2]++;
      if (move_right) n_mv[3]++;
      if (game_reset_req) n_req++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int b_up, b_dn, b_lf, b_rt, b_req, segs;
    logic [3:0] v;

    // Reset state
    step(3);
    check("reset_sw_state", {28'd0, sw_state}, 32'd0);
    check("reset_moves", {28'd0, move_right, move_left, move_down, move_up}, 32'd0);
    check("reset_req", {31'd0, game_reset_req}, 32'd0);
    reset = 1'b0;
    step(2);

    // 1. Clean press of switch1
    b_up = n_mv[0];
    drive(4'b0001);
    step(5); check("t1_sw_before", {31'd0, sw_state[0]}, 32'd0);
    step(1); check("t1_sw_at6", {31'd0, sw_state[0]}, 32'd1);
             check("t1_up_at6", {31'd0, move_up}, 32'd0);
    step(1); check("t1_up_at7", {31'd0, move_up}, 32'd1);
    step(1); check("t1_up_at8", {31'd0, move_up}, 32'd0);
    drive(4'b0000);
    step(12); check("t1_up_count", n_mv[0] - b_up, 32'd1);

    // 2. Bouncing switch3, then held
    b_lf = n_mv[2];
    for (int i = 0; i < 10; i++) begin
      drive((i % 2 == 0) ? 4'b0100 : 4'b0000);
      step(2);
    end
    drive(4'b0100);
    step(6); check("t2_left_at6", {31'd0, move_left}, 32'd0);
    step(1); check("t2_left_at7", {31'd0, move_left}, 32'd1);
    step(3); check("t2_left_count", n_mv[2] - b_lf, 32'd1);
    drive(4'b0000);
    step(12);

    // 3. Second switch pressed while first is held
    b_rt = n_mv[3]; b_dn = n_mv[1];
    drive(4'b1000); step(10);
    drive(4'b1010); step(10);
    check("t3_right_count", n_mv[3] - b_rt, 32'd1);
    check("t3_down_none", n_mv[1] - b_dn, 32'd0);
    drive(4'b0000); step(10);
    drive(4'b0010); step(10);
    check("t3_down_count", n_mv[1] - b_dn, 32'd1);
    drive(4'b0000); step(10);

    // 4. Four-switch chord
    b_up = n_mv[0]; b_dn = n_mv[1]; b_lf = n_mv[2]; b_rt = n_mv[3]; b_req = n_req;
    drive(4'b1111);
    step(6);  check("t4_sw_full", {28'd0, sw_state}, 32'hF);
    step(15); check("t4_req_at21", {31'd0, game_reset_req}, 32'd0);
    step(1);  check("t4_req_at22", {31'd0, game_reset_req}, 32'd1);
    step(1);  check("t4_req_at23", {31'd0, game_reset_req}, 32'd0);
    step(17);
    drive(4'b1110); step(15);
    drive(4'b1111); step(40);
    check("t4_req_once", n_req - b_req, 32'd1);
    drive(4'b0000); step(15);
    check("t4_no_moves", (n_mv[0] - b_up) + (n_mv[1] - b_dn) + (n_mv[2] - b_lf) + (n_mv[3] - b_rt), 32'd0);

    // 5. Reset in the middle of a chord hold
    drive(4'b1111);
    step(17);
    reset = 1'b1;
    #1;
    check("t5_sw_in_reset", {28'd0, sw_state}, 32'd0);
    check("t5_out_in_reset", {27'd0, move_right, move_left, move_down, move_up, game_reset_req}, 32'd0);
    step(3);
    reset = 1'b0;
    b_req = n_req;
    step(21); check("t5_req_at21", {31'd0, game_reset_req}, 32'd0);
    step(1);  check("t5_req_at22", {31'd0, game_reset_req}, 32'd1);
    step(2);  check("t5_req_count", n_req - b_req, 32'd1);
    drive(4'b0000); step(15);

    // 6. Long hold of switch1
    b_up = n_mv[0];
    drive(4'b0001);
    step(7);  check("t6_up_at7", {31'd0, move_up}, 32'd1);
    step(20); check("t6_up_at27", {31'd0, move_up}, EXP_AT_27);
    step(34); check("t6_up_count", n_mv[0] - b_up, EXP_HOLD_PULSES);
    drive(4'b0000); step(12);

    // Randomized activity, checked by the per-cycle model compare
    segs = 0;
    while (segs < 350) begin
      int mode, len;
      mode = $urandom_range(0, 9);
      if (mode <= 4) begin
        v = 4'($urandom_range(0, 15)); len = $urandom_range(1, 12);
      end else if (mode <= 7) begin
        v = 4'(1 << $urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) v = 4'($urandom_range(0, 15));
        len = $urandom_range(8, 34);
      end else if (mode == 8) begin
        v = 4'hF; len = $urandom_range(18, 45);
      end else begin
        v = 4'h0; len = $urandom_range(8, 20);
      end
      drive(v);
      step(len);
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        step($urandom_range(1, 3));
        reset = 1'b0;
      end
      segs++;
    end
    drive(4'b0000);
    step(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
